// File: rtl/filt_fir_interp_pkg.sv
// -----------------------------------------------------------------------------
// filt_fir_interp_pkg
// Shared types, constants and elaboration-time helpers for the polyphase
// interpolating FIR (filt_fir_interp) and its MAC sub-module.
//   clog2_ceil      : ceil(log2(v)), 0 for v <= 1
//   taps_per_phase  : K = ceil(N / L)
//   coeff_at        : bounds-safe coefficient lookup (0 outside h[0..N-1])
//   coeff_arr_t     : fixed-capacity coefficient table, unused entries are 0
//   C_COEFFS_DEFAULT: 16-tap symmetric lowpass
//   C_TB_COEFFS     : {1,2,3,4} for directed tests
// -----------------------------------------------------------------------------
package filt_fir_interp_pkg;

    localparam int C_MAX_TAPS = 64;

    typedef int coeff_arr_t [C_MAX_TAPS];

    function automatic int clog2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int taps_per_phase(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

    // Taps past the end of the filter read as zero, which is how the short
    // phases of an N that is not a multiple of L get their padding.
    function automatic int coeff_at(input coeff_arr_t arr, input int idx, input int n);
        if (idx >= n || idx >= C_MAX_TAPS) begin
            return 0;
        end
        return arr[idx];
    endfunction

    localparam coeff_arr_t C_COEFFS_DEFAULT = '{
        0: -76,   1: -254,  2: -378,  3: 0,
        4: 1347,  5: 3513,  6: 5629,  7: 6803,
        8: 6803,  9: 5629, 10: 3513, 11: 1347,
        12: 0,   13: -378, 14: -254, 15: -76,
        default: 0
    };

    localparam coeff_arr_t C_TB_COEFFS = '{0: 1, 1: 2, 2: 3, 3: 4, default: 0};

endpackage

// File: rtl/filt_fir_interp_mac.sv
// -----------------------------------------------------------------------------
// filt_fir_interp_mac
// Purely combinational dot product for one polyphase branch:
//   o_sum = sum_k i_coef[k] * i_x[k], full precision, sign-extended.
// Ports:
//   i_coef [K]  signed coefficients of the current phase
//   i_x    [K]  signed delay-line contents (already updated for this edge)
//   o_sum       signed full-precision sum, gp_oup_width bits
// -----------------------------------------------------------------------------
module filt_fir_interp_mac #(
    parameter int gp_taps        = 4,
    parameter int gp_inp_width   = 16,
    parameter int gp_coeff_width = 16,
    parameter int gp_oup_width   = 34
) (
    input  logic signed [gp_coeff_width-1:0] i_coef [gp_taps],
    input  logic signed [gp_inp_width-1:0]   i_x    [gp_taps],
    output logic signed [gp_oup_width-1:0]   o_sum
);

    localparam int PW = gp_inp_width + gp_coeff_width;

    logic signed [PW-1:0]           w_prod [gp_taps];
    logic signed [gp_oup_width-1:0] w_acc;

    always_comb begin
        for (int k = 0; k < gp_taps; k++) begin
            // Widen both operands first so the product is formed at PW bits.
            w_prod[k] = PW'(i_coef[k]) * PW'(i_x[k]);
        end
    end

    always_comb begin
        // NOTE: combinational blocks assign every output a default before any
        // conditional or loop, so no path leaves a value held (no latch).
        w_acc = '0;
        for (int k = 0; k < gp_taps; k++) begin
            w_acc = w_acc + gp_oup_width'(w_prod[k]);
        end
    end

    assign o_sum = w_acc;

endmodule

// File: rtl/filt_fir_interp.sv
// -----------------------------------------------------------------------------
// filt_fir_interp
// Polyphase interpolating FIR, upsampling factor L. One input sample is taken
// every L enabled cycles (when o_rdy=1), one output sample leaves every enabled
// cycle. Equivalent to zero-stuffing by L and filtering with h[0..N-1], but
// only the K = ceil(N/L) non-zero products of the active phase are computed.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_an  synchronous reset, active-low, overrides i_ena
//   i_ena     clock enable, all state holds when low
//   i_data    signed input sample, consumed when o_rdy & i_ena at an edge
//   o_rdy     next enabled edge consumes i_data (phase counter == 0)
//   o_phase   phase index of the sample on o_data
//   o_data    signed full-precision interpolated output
// -----------------------------------------------------------------------------
module filt_fir_interp
    import filt_fir_interp_pkg::*;
#(
    parameter int         gp_inp_width    = 16,
    parameter int         gp_coeff_length = 16,
    parameter int         gp_coeff_width  = 16,
    parameter int         gp_interp_l     = 4,
    parameter coeff_arr_t gp_coeffs       = C_COEFFS_DEFAULT,
    parameter int         gp_oup_width    = gp_inp_width + gp_coeff_width
                                            + clog2_ceil(taps_per_phase(gp_coeff_length, gp_interp_l))
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst_an,
    input  logic                                      i_ena,
    input  logic signed [gp_inp_width-1:0]            i_data,
    output logic                                      o_rdy,
    output logic [clog2_ceil(gp_interp_l)-1:0]        o_phase,
    output logic signed [gp_oup_width-1:0]            o_data
);

    localparam int K    = taps_per_phase(gp_coeff_length, gp_interp_l);
    localparam int PH_W = clog2_ceil(gp_interp_l);
    localparam int CW   = gp_coeff_width;
    localparam int IW   = gp_inp_width;

    logic [PH_W-1:0]              r_ph;
    logic signed [IW-1:0]         r_x [K];
    logic signed [gp_oup_width-1:0] r_data;
    logic [PH_W-1:0]              r_phase;

    logic signed [IW-1:0]         w_x_next [K];
    logic signed [CW-1:0]         w_coef   [K];
    logic signed [gp_oup_width-1:0] w_sum;

    // The delay line only shifts on the edge that accepts a new sample; the
    // remaining L-1 phases reuse the same K samples with other coefficients.
    always_comb begin
        w_x_next = r_x;
        if (r_ph == '0) begin
            w_x_next[0] = i_data;
            for (int k = 1; k < K; k++) begin
                w_x_next[k] = r_x[k-1];
            end
        end
    end

    // Phase p uses taps h[k*L + p]; the mux selects one column of that table.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            w_coef[k] = '0;
            for (int p = 0; p < gp_interp_l; p++) begin
                if (r_ph == PH_W'(p)) begin
                    w_coef[k] = CW'(coeff_at(gp_coeffs, k * gp_interp_l + p, gp_coeff_length));
                end
            end
        end
    end

    filt_fir_interp_mac #(
        .gp_taps        (K),
        .gp_inp_width   (IW),
        .gp_coeff_width (CW),
        .gp_oup_width   (gp_oup_width)
    ) u_mac (
        .i_coef (w_coef),
        .i_x    (w_x_next),
        .o_sum  (w_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            r_ph    <= '0;
            r_data  <= '0;
            r_phase <= '0;
            // NOTE: the delay line is reset explicitly, because a reset must
            // discard samples in flight rather than let them leak into outputs.
            for (int k = 0; k < K; k++) begin
                r_x[k] <= '0;
            end
        end else if (i_ena) begin
            r_x     <= w_x_next;
            r_data  <= w_sum;
            r_phase <= r_ph;
            r_ph    <= (r_ph == PH_W'(gp_interp_l - 1)) ? '0 : r_ph + PH_W'(1);
        end
    end

    assign o_rdy   = (r_ph == '0);
    assign o_phase = r_phase;
    assign o_data  = r_data;

endmodule

// File: tb/tb_filt_fir_interp.sv
// -----------------------------------------------------------------------------
// tb_filt_fir_interp
// Directed bench: small N=4/L=2 instance with coefficients {1,2,3,4} and
// hand-computed sequences, plus N=16 and N=15 (L=4, default coefficients)
// instances compared against a zero-stuff + convolve model.
// -----------------------------------------------------------------------------
module tb_filt_fir_interp;
    import filt_fir_interp_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_an;
    logic i_ena;

    logic signed [15:0] data_s;
    logic signed [15:0] data_b;

    logic               rdy_s;
    logic [0:0]         phase_s;
    logic signed [32:0] out_s;

    logic               rdy16;
    logic [1:0]         phase16;
    logic signed [33:0] out16;

    logic               rdy15;
    logic [1:0]         phase15;
    logic signed [33:0] out15;

    int n_checks = 0;
    int n_pass   = 0;

    longint u [16];
    longint y16;
    longint y15;

    int exp_imp  [6] = '{1, 2, 3, 4, 0, 0};
    int exp_step [6] = '{5, 10, 20, 30, 20, 30};

    always #5 i_clk = ~i_clk;

    filt_fir_interp #(
        .gp_inp_width    (16),
        .gp_coeff_length (4),
        .gp_coeff_width  (16),
        .gp_interp_l     (2),
        .gp_coeffs       (C_TB_COEFFS)
    ) u_dut (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_data   (data_s),
        .o_rdy    (rdy_s),
        .o_phase  (phase_s),
        .o_data   (out_s)
    );

    filt_fir_interp #(
        .gp_coeff_length (16),
        .gp_interp_l     (4)
    ) u_dut16 (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_data   (data_b),
        .o_rdy    (rdy16),
        .o_phase  (phase16),
        .o_data   (out16)
    );

    filt_fir_interp #(
        .gp_coeff_length (15),
        .gp_interp_l     (4)
    ) u_dut15 (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_ena    (i_ena),
        .i_data   (data_b),
        .o_rdy    (rdy15),
        .o_phase  (phase15),
        .o_data   (out15)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks = n_checks + 1;
        if (obs == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst_an = 1'b0;
        i_ena    = 1'b1;
        data_s   = '0;
        data_b   = '0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_data",  out_s,   0);
            check("rst_phase", phase_s, 0);
            check("rst_rdy",   rdy_s,   1);
        end

        // Release: o_rdy alternates 1,0,1,0 ahead of consecutive edges.
        i_rst_an = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rel_rdy", rdy_s, (i % 2 == 0) ? 1 : 0);
            tick();
            check("rel_data", out_s, 0);
        end

        // Impulse.
        for (int i = 0; i < 6; i++) begin
            data_s = (i == 0) ? 16'sd1 : 16'sd0;
            tick();
            check("imp_data",  out_s,   exp_imp[i]);
            check("imp_phase", phase_s, i % 2);
        end

        // Step of 5; i_data held, only consumed when o_rdy is high.
        data_s = 16'sd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("step_data", out_s, exp_step[i]);
        end

        // Flush the delay line with two zero samples.
        data_s = '0;
        for (int i = 0; i < 4; i++) tick();
        check("flush_rdy", rdy_s, 1);

        // Enable gating in the middle of an impulse.
        data_s = 16'sd1;
        tick();
        check("gate_d0", out_s, 1);
        data_s = 16'sd0;
        tick();
        check("gate_d1", out_s, 2);
        i_ena  = 1'b0;
        data_s = 16'sd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gate_hold_data",  out_s,   2);
            check("gate_hold_phase", phase_s, 1);
            check("gate_hold_rdy",   rdy_s,   1);
        end
        i_ena  = 1'b1;
        data_s = 16'sd0;
        tick();
        check("gate_d2", out_s, 3);
        tick();
        check("gate_d3", out_s, 4);

        // Step of 5 for three edges leaves ph=1, then reset mid-stream.
        data_s = 16'sd5;
        tick();
        check("mrst_s0", out_s, 5);
        tick();
        check("mrst_s1", out_s, 10);
        tick();
        check("mrst_s2", out_s, 20);
        check("mrst_pre_rdy", rdy_s, 0);
        i_rst_an = 1'b0;
        tick();
        check("mrst_data",  out_s,   0);
        check("mrst_phase", phase_s, 0);
        check("mrst_rdy",   rdy_s,   1);
        i_rst_an = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_s = (i == 0) ? 16'sd1 : 16'sd0;
            tick();
            check("mrst_imp", out_s, exp_imp[i]);
        end

        // Full-size instances: fresh reset, then 1000 extreme samples.
        i_rst_an = 1'b0;
        tick();
        check("big_rst16", out16, 0);
        check("big_rst15", out15, 0);
        i_rst_an = 1'b1;
        for (int j = 0; j < 16; j++) u[j] = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 4 == 0) begin
                data_b = ((n / 4) % 2 == 0) ? 16'sh8000 : 16'sh7fff;
            end else begin
                // Not consumed: the model stuffs a zero here.
                data_b = 16'sd1234;
            end
            check("big_rdy16", rdy16, (n % 4 == 0) ? 1 : 0);
            check("big_rdy15", rdy15, (n % 4 == 0) ? 1 : 0);
            tick();
            for (int j = 15; j > 0; j--) u[j] = u[j-1];
            u[0] = (n % 4 == 0) ? longint'(data_b) : 0;
            y16 = 0;
            y15 = 0;
            for (int j = 0; j < 16; j++) begin
                y16 = y16 + longint'(C_COEFFS_DEFAULT[j]) * u[j];
                if (j < 15) y15 = y15 + longint'(C_COEFFS_DEFAULT[j]) * u[j];
            end
            check("n16_data",  out16,   y16);
            check("n16_phase", phase16, n % 4);
            check("n15_data",  out15,   y15);
            check("n15_phase", phase15, n % 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/filt_fir_interp.md
Name: filt_fir_interp

Overview:
- Polyphase interpolating FIR filter, upsampling factor gp_interp_l.
- Takes one input sample every gp_interp_l enabled cycles and produces one output sample every enabled cycle.
- Sits downstream of rate-reducing stages in the filter chain, on the same clock and i_ena clock-enable scheme as the single-rate filt_fir.
- Equivalent to zero-stuffing the input by L followed by FIR filtering with the full coefficient set, without computing the zero products.

Parameters:
- gp_inp_width, 16: input sample width, signed two's complement.
- gp_coeff_length, 16: total number of taps N.
- gp_coeff_width, 16: coefficient width, signed.
- gp_interp_l, 4: interpolation factor L, valid range ≥2.
- gp_coeffs, filt_fir_interp_pkg::C_COEFFS_DEFAULT: array [N] of signed coefficients h[0..N-1].
- gp_oup_width, gp_inp_width+gp_coeff_width+$clog2(K): output width, full precision; K = ceil(N/L) taps per phase.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_an  in  1  synchronous reset, active-low.
- i_ena  in  1  clock enable; when low, all state holds.
- i_data  in  gp_inp_width  signed input sample; consumed only when o_rdy=1 and i_ena=1 at a rising edge.
- o_rdy  out  1  high when the next enabled edge consumes i_data (phase counter = 0).
- o_phase  out  $clog2(L)  phase index of the sample currently on o_data.
- o_data  out  gp_oup_width  signed interpolated output sample.

Behaviour:
- Reset (i_rst_an=0 at a rising edge, takes priority over i_ena):
  - phase counter ph <= 0; delay line x[0..K-1] <= 0.
  - o_data <= 0, o_phase <= 0, o_rdy = 1.
- i_ena=0: ph, delay line, o_data and o_phase all hold. o_rdy reflects the held ph.
- o_rdy = (ph == 0). It is decoded combinationally from the ph register, so there is no combinational path from any input.
- Each enabled edge:
  - x_next = (ph==0) ? {i_data, x[0..K-2]} : x.
  - x <= x_next.
  - o_data <= sum over k=0..K-1 of h[k*L+ph]*x_next[k]; any term with k*L+ph ≥ N is 0.
  - o_phase <= ph.
  - ph <= (ph==L-1) ? 0 : ph+1.
- Latency: the output for phase 0 that includes an accepted sample appears on o_data one edge after acceptance. Successive phases follow on consecutive enabled edges.
- Arithmetic:
  - Products are full precision, gp_inp_width+gp_coeff_width bits.
  - The accumulator is gp_oup_width bits, sign-extended, with no rounding, truncation or saturation.
  - This width is guaranteed overflow-free.
- N not a multiple of L: the short phases zero-pad the missing taps. No error, no change in timing.
- Wrap-around: ph wraps from L-1 to 0 on an enabled edge. o_rdy rises combinationally in the same cycle.
- Reset while ph≠0: takes effect on that edge. Samples in flight are discarded. o_rdy=1 on the cycle after reset deasserts.
- Upstream must present a valid i_data whenever o_rdy=1 and i_ena=1. There is no stall or backpressure; a missed sample is the source's fault.
- One combinational dot product per cycle: K multipliers and a K-input adder tree. It is not pipelined.

Decomposition:
- filt_fir_interp_pkg holds:
  - function clog2_ceil;
  - function taps_per_phase(N, L);
  - typedef coeff_arr_t;
  - C_COEFFS_DEFAULT (16-tap lowpass);
  - C_TB_COEFFS = {1,2,3,4} for the directed tests.
- Sub-module filt_fir_interp_mac: purely combinational. Inputs are the phase coefficient vector (K entries) and x_next; output is the full-precision sum. The top level holds ph, the delay line, the coefficient mux per phase and the output registers.

Test Plan (N=4, L=2, coeffs {1,2,3,4}, widths 16/16, unless stated):
- Reset release: hold i_rst_an=0 for 3 edges, then release with i_ena=1 → o_data=0, o_phase=0, o_rdy=1 during reset; o_rdy toggles 1,0,1,0 afterwards.
- Impulse: i_data=1 at the first o_rdy, then 0 → o_data = 1,2,3,4 on successive edges (o_phase 0,1,0,1), then 0 thereafter.
- Step: i_data=5 at every o_rdy → o_data = 5,10,20,30,20,30,... steady state.
- Enable gating: deassert i_ena for 3 cycles mid-impulse after o_data=2 → o_data holds 2 and o_phase holds 1; the sequence resumes 3,4 on re-enable.
- Mid-operation reset: assert i_rst_an=0 one edge while ph=1 after a step of 5 → next o_data=0, o_rdy=1, the delay line is cleared, and a new impulse reproduces 1,2,3,4.
- Extremes plus reference model: N=16, L=4, default coefficients.
  - i_data alternating -32768 and 32767 → outputs bit-exact against the zero-stuff+convolve golden model over 1000 samples.
  - No overflow.
  - N=15 case: the zero-padded phase output matches the golden model.
